// File: rtl/mem_wb_pipe_stage.sv
// MEM->WB stage register with valid/ready handshake, optional skid entry,
// flush, writeback result select and saturating stall/bubble counters.
module mem_wb_pipe_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter bit SKID   = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              m_valid,
    output logic              m_ready,
    input  logic              m_reg_write,
    input  logic              m_mem_to_reg,
    input  logic [DATA_W-1:0] m_read_data,
    input  logic [DATA_W-1:0] m_alu_out,
    input  logic [REG_AW-1:0] m_write_reg,
    output logic              w_valid,
    input  logic              w_ready,
    output logic              w_reg_write,
    output logic              w_mem_to_reg,
    output logic [DATA_W-1:0] w_read_data,
    output logic [DATA_W-1:0] w_alu_out,
    output logic [REG_AW-1:0] w_write_reg,
    output logic [DATA_W-1:0] w_result,
    output logic              w_we,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    state_t stateNext;

    logic mFire;
    logic wFire;
    logic wValid;
    logic mReady;
    logic mReadyQ;

    logic              outRegWrite;
    logic              outMemToReg;
    logic [DATA_W-1:0] outReadData;
    logic [DATA_W-1:0] outAluOut;
    logic [REG_AW-1:0] outWriteReg;

    logic              skRegWrite;
    logic              skMemToReg;
    logic [DATA_W-1:0] skReadData;
    logic [DATA_W-1:0] skAluOut;
    logic [REG_AW-1:0] skWriteReg;

    logic loadOutM;
    logic loadOutSk;
    logic loadSk;

    logic [CNT_W-1:0] stallCnt;
    logic [CNT_W-1:0] bubbleCnt;

    assign mFire = m_valid & mReady;
    assign wFire = wValid & w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        if (flush) begin
            stateNext = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (mFire) stateNext = ONE;
                end
                ONE: begin
                    if (SKID && mFire && !wFire) stateNext = FULL;
                    else if (!mFire && wFire) stateNext = EMPTY;
                end
                FULL: begin
                    if (wFire) stateNext = ONE;
                end
                default: stateNext = EMPTY;
            endcase
        end
    end

    // Without the skid entry, ready is combinational but still forced low in reset.
    always_comb begin
        wValid = (state != EMPTY);
        mReady = SKID ? mReadyQ : (rst_n & (!wValid | w_ready));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mReadyQ <= 1'b0;
        end else begin
            mReadyQ <= (stateNext != FULL);
        end
    end

    assign loadOutM  = !flush & mFire & ((state == EMPTY) | wFire);
    assign loadOutSk = !flush & (state == FULL) & wFire;
    assign loadSk    = !flush & SKID & (state == ONE) & mFire & !wFire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outRegWrite <= 1'b0;
            outMemToReg <= 1'b0;
            outReadData <= '0;
            outAluOut   <= '0;
            outWriteReg <= '0;
            skRegWrite  <= 1'b0;
            skMemToReg  <= 1'b0;
            skReadData  <= '0;
            skAluOut    <= '0;
            skWriteReg  <= '0;
        end else begin
            if (flush) begin
                outRegWrite <= 1'b0;
                skRegWrite  <= 1'b0;
            end
            if (loadOutM) begin
                outRegWrite <= m_reg_write;
                outMemToReg <= m_mem_to_reg;
                outReadData <= m_read_data;
                outAluOut   <= m_alu_out;
                outWriteReg <= m_write_reg;
            end else if (loadOutSk) begin
                outRegWrite <= skRegWrite;
                outMemToReg <= skMemToReg;
                outReadData <= skReadData;
                outAluOut   <= skAluOut;
                outWriteReg <= skWriteReg;
            end
            if (loadSk) begin
                skRegWrite <= m_reg_write;
                skMemToReg <= m_mem_to_reg;
                skReadData <= m_read_data;
                skAluOut   <= m_alu_out;
                skWriteReg <= m_write_reg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt  <= '0;
            bubbleCnt <= '0;
        end else begin
            if (wValid && !w_ready && stallCnt != '1) begin
                stallCnt <= stallCnt + CNT_W'(1);
            end
            if (!wValid && bubbleCnt != '1) begin
                bubbleCnt <= bubbleCnt + CNT_W'(1);
            end
        end
    end

    assign m_ready      = mReady;
    assign w_valid      = wValid;
    assign w_reg_write  = outRegWrite;
    assign w_mem_to_reg = outMemToReg;
    assign w_read_data  = outReadData;
    assign w_alu_out    = outAluOut;
    assign w_write_reg  = outWriteReg;
    assign w_result     = outMemToReg ? outReadData : outAluOut;
    assign w_we         = wFire & outRegWrite & (outWriteReg != '0);
    assign stall_cnt    = stallCnt;
    assign bubble_cnt   = bubbleCnt;

endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
// Bench for mem_wb_pipe_stage: scoreboard of fired beats plus
// directed reset, streaming, backpressure, flush, result and saturation tests.
module tb_mem_wb_pipe_stage;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 16;

    typedef struct packed {
        logic          rw;
        logic          m2r;
        logic [DW-1:0] rd;
        logic [DW-1:0] alu;
        logic [AW-1:0] wr;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          m_valid = 1'b0;
    logic          m_ready;
    logic          m_reg_write = 1'b0;
    logic          m_mem_to_reg = 1'b0;
    logic [DW-1:0] m_read_data = '0;
    logic [DW-1:0] m_alu_out = '0;
    logic [AW-1:0] m_write_reg = '0;
    logic          w_valid;
    logic          w_ready = 1'b0;
    logic          w_reg_write;
    logic          w_mem_to_reg;
    logic [DW-1:0] w_read_data;
    logic [DW-1:0] w_alu_out;
    logic [AW-1:0] w_write_reg;
    logic [DW-1:0] w_result;
    logic          w_we;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] bubble_cnt;

    logic          sMReady;
    logic          sWValid;
    logic          sWRegWrite;
    logic          sWMemToReg;
    logic [DW-1:0] sWReadData;
    logic [DW-1:0] sWAluOut;
    logic [AW-1:0] sWWriteReg;
    logic [DW-1:0] sWResult;
    logic          sWWe;
    logic [3:0]    sStallCnt;
    logic [3:0]    sBubbleCnt;

    beat_t sbQ[$];
    beat_t expB;
    beat_t gotB;
    int checks = 0;
    int errors = 0;

    mem_wb_pipe_stage #(
        .DATA_W(DW), .REG_AW(AW), .SKID(1'b1), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_reg_write(m_reg_write), .m_mem_to_reg(m_mem_to_reg),
        .m_read_data(m_read_data), .m_alu_out(m_alu_out),
        .m_write_reg(m_write_reg),
        .w_valid(w_valid), .w_ready(w_ready),
        .w_reg_write(w_reg_write), .w_mem_to_reg(w_mem_to_reg),
        .w_read_data(w_read_data), .w_alu_out(w_alu_out),
        .w_write_reg(w_write_reg), .w_result(w_result), .w_we(w_we),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    mem_wb_pipe_stage #(
        .DATA_W(DW), .REG_AW(AW), .SKID(1'b1), .CNT_W(4)
    ) dutSat (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .m_valid(1'b0), .m_ready(sMReady),
        .m_reg_write(1'b0), .m_mem_to_reg(1'b0),
        .m_read_data('0), .m_alu_out('0), .m_write_reg('0),
        .w_valid(sWValid), .w_ready(1'b1),
        .w_reg_write(sWRegWrite), .w_mem_to_reg(sWMemToReg),
        .w_read_data(sWReadData), .w_alu_out(sWAluOut),
        .w_write_reg(sWWriteReg), .w_result(sWResult), .w_we(sWWe),
        .stall_cnt(sStallCnt), .bubble_cnt(sBubbleCnt)
    );

    // Scoreboard: push on upstream fire, pop on downstream fire; flush drops all.
    always @(negedge clk) begin
        if (rst_n) begin
            if (flush) begin
                sbQ.delete();
            end else begin
                if (w_valid && w_ready) begin
                    checks++;
                    gotB = '{w_reg_write, w_mem_to_reg, w_read_data,
                             w_alu_out, w_write_reg};
                    if (sbQ.size() == 0) begin
                        errors++;
                        $display("FAIL scoreboard unexpected beat got=%h", gotB);
                    end else begin
                        expB = sbQ.pop_front();
                        if (gotB !== expB) begin
                            errors++;
                            $display("FAIL scoreboard got=%h exp=%h", gotB, expB);
                        end
                    end
                end
                if (m_valid && m_ready) begin
                    sbQ.push_back('{m_reg_write, m_mem_to_reg, m_read_data,
                                    m_alu_out, m_write_reg});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r,
                         input logic [DW-1:0] rd, input logic [DW-1:0] alu,
                         input logic [AW-1:0] wr);
        m_valid      = v;
        m_reg_write  = rw;
        m_mem_to_reg = m2r;
        m_read_data  = rd;
        m_alu_out    = alu;
        m_write_reg  = wr;
    endtask

    task automatic do_reset();
        m_valid = 1'b0;
        flush   = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        sbQ.delete();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [199:0] outs;
        #2;
        outs = {m_ready, w_valid, w_reg_write, w_mem_to_reg, w_read_data,
                w_alu_out, w_write_reg, w_result, w_we, stall_cnt, bubble_cnt};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0", outs);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        checks++;
        if (m_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_early got=%b exp=0", m_ready);
        end
        tick();
        checks++;
        if (m_ready !== 1'b1 || bubble_cnt !== 16'd1) begin
            errors++;
            $display("FAIL reset_ready_rise got=%b/%0d exp=1/1", m_ready, bubble_cnt);
        end
        w_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h55, 5'd3);
        tick();
        m_valid = 1'b0;
        checks++;
        if (w_valid !== 1'b1 || w_alu_out !== 32'h55) begin
            errors++;
            $display("FAIL reset_prestream got=%b/%h exp=1/55", w_valid, w_alu_out);
        end
        tick();
        #2 rst_n = 1'b0;
        sbQ.delete();
        #1;
        outs = {m_ready, w_valid, w_reg_write, w_mem_to_reg, w_read_data,
                w_alu_out, w_write_reg, w_result, w_we, stall_cnt, bubble_cnt};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_midstream got=%h exp=0", outs);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        checks++;
        if (m_ready !== 1'b1 || w_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_recover got=%b/%b exp=1/0", m_ready, w_valid);
        end
    endtask

    task automatic test_streaming();
        logic [DW-1:0] e;
        w_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            e = DW'((i + 1) * 16);
            drive(1'b1, 1'b1, 1'b0, 32'h0, e, AW'(i + 1));
            tick();
            checks++;
            if (w_valid !== 1'b1 || w_alu_out !== e || m_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_%0d got=%b/%h/%b exp=1/%h/1",
                         i, w_valid, w_alu_out, m_ready, e);
            end
        end
        m_valid = 1'b0;
        tick();
        checks++;
        if (w_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_end got=%b exp=0", w_valid);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        w_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'hA0, 5'd1);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'hB0, 5'd2);
        tick();
        checks++;
        if (m_ready !== 1'b0 || w_alu_out !== 32'hA0) begin
            errors++;
            $display("FAIL bp_full got=%b/%h exp=0/a0", m_ready, w_alu_out);
        end
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'hC0, 5'd3);
        tick();
        checks++;
        if (m_ready !== 1'b0 || w_alu_out !== 32'hA0) begin
            errors++;
            $display("FAIL bp_hold got=%b/%h exp=0/a0", m_ready, w_alu_out);
        end
        tick();
        checks++;
        if (stall_cnt !== 16'd3) begin
            errors++;
            $display("FAIL bp_stall got=%0d exp=3", stall_cnt);
        end
        w_ready = 1'b1;
        tick();
        checks++;
        if (w_alu_out !== 32'hB0 || m_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_drain_b got=%h/%b exp=b0/1", w_alu_out, m_ready);
        end
        tick();
        m_valid = 1'b0;
        checks++;
        if (w_alu_out !== 32'hC0 || w_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_drain_c got=%h/%b exp=c0/1", w_alu_out, w_valid);
        end
        tick();
        checks++;
        if (w_valid !== 1'b0 || stall_cnt !== 16'd3) begin
            errors++;
            $display("FAIL bp_end got=%b/%0d exp=0/3", w_valid, stall_cnt);
        end
    endtask

    task automatic test_flush();
        w_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'hF1, 5'd4);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'hF2, 5'd5);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'hF3, 5'd6);
        flush = 1'b1;
        tick();
        flush   = 1'b0;
        m_valid = 1'b0;
        checks++;
        if (w_valid !== 1'b0 || m_ready !== 1'b1 || w_reg_write !== 1'b0) begin
            errors++;
            $display("FAIL flush_full got=%b/%b/%b exp=0/1/0",
                     w_valid, m_ready, w_reg_write);
        end
        checks++;
        if (stall_cnt !== 16'd5) begin
            errors++;
            $display("FAIL flush_keeps_cnt got=%0d exp=5", stall_cnt);
        end
        w_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (w_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_ghost_%0d got=%b exp=0", i, w_valid);
            end
        end
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'hF4, 5'd7);
        flush = 1'b1;
        tick();
        flush   = 1'b0;
        m_valid = 1'b0;
        checks++;
        if (w_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_drop_fire got=%b exp=0", w_valid);
        end
    endtask

    task automatic test_result_we();
        w_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 32'h1234, 5'd8);
        tick();
        checks++;
        if (w_result !== 32'hDEADBEEF || w_we !== 1'b1) begin
            errors++;
            $display("FAIL result_mem got=%h/%b exp=deadbeef/1", w_result, w_we);
        end
        drive(1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 32'h1234, 5'd0);
        tick();
        checks++;
        if (w_result !== 32'hDEADBEEF || w_we !== 1'b0) begin
            errors++;
            $display("FAIL we_zero_reg got=%h/%b exp=deadbeef/0", w_result, w_we);
        end
        drive(1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 32'h1234, 5'd8);
        tick();
        m_valid = 1'b0;
        w_ready = 1'b0;
        #1;
        checks++;
        if (w_result !== 32'h1234 || w_we !== 1'b0) begin
            errors++;
            $display("FAIL result_alu_stalled got=%h/%b exp=1234/0", w_result, w_we);
        end
        w_ready = 1'b1;
        #1;
        checks++;
        if (w_we !== 1'b1) begin
            errors++;
            $display("FAIL we_alu got=%b exp=1", w_we);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        for (int i = 0; i < 300; i++) begin
            drive(($urandom % 4) != 0, 1'($urandom), 1'($urandom),
                  $urandom, $urandom, AW'($urandom));
            w_ready = ($urandom % 3) != 0;
            tick();
        end
        m_valid = 1'b0;
        w_ready = 1'b1;
        n = 0;
        while ((w_valid || sbQ.size() != 0) && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (w_valid !== 1'b0 || sbQ.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain got=%b/%0d exp=0/0", w_valid, sbQ.size());
        end
    endtask

    task automatic test_saturation();
        do_reset();
        repeat (4) tick();
        checks++;
        if (sBubbleCnt !== 4'd5) begin
            errors++;
            $display("FAIL sat_count got=%0d exp=5", sBubbleCnt);
        end
        repeat (15) tick();
        checks++;
        if (sBubbleCnt !== 4'd15) begin
            errors++;
            $display("FAIL sat_top got=%0d exp=15", sBubbleCnt);
        end
        repeat (5) tick();
        checks++;
        if (sBubbleCnt !== 4'd15 || bubble_cnt !== 16'd25) begin
            errors++;
            $display("FAIL sat_hold got=%0d/%0d exp=15/25", sBubbleCnt, bubble_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_result_we();
        test_back_to_back();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
